// File: rtl/rgb_filter_pkg.sv
// rgb_filter_pkg: shared mode/key encodings and luma weights for the RGB filters
package rgb_filter_pkg;
  typedef enum logic [1:0] {MODE_PASS, MODE_GRAY, MODE_KEY, MODE_BIN} mode_e;
  typedef enum logic [1:0] {KEY_R, KEY_G, KEY_B} key_e;
  localparam int W_R   = 77;
  localparam int W_G   = 150;
  localparam int W_B   = 29;
  localparam int Y_RND = 128;
endpackage

// File: rtl/rgb_luma.sv
// rgb_luma: combinational rounded BT.601-style luma from a packed {R,G,B} pixel
module rgb_luma
  import rgb_filter_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [3*CW-1:0] pixel,
  output logic [CW-1:0]   y
);
  localparam int SUM_W = CW + 9;
  logic [SUM_W-1:0] sum;
  assign sum = SUM_W'(W_R) * SUM_W'(pixel[3*CW-1:2*CW])
             + SUM_W'(W_G) * SUM_W'(pixel[2*CW-1:CW])
             + SUM_W'(W_B) * SUM_W'(pixel[CW-1:0])
             + SUM_W'(Y_RND);
  // weights sum to 256, so the shifted sum always fits in CW bits
  assign y = CW'(sum >> 8);
endmodule

// File: rtl/rgb_color_key_pipe.sv
// rgb_color_key_pipe: two-stage valid/ready pixel filter (pass, grey, colour-key, binarise)
module rgb_color_key_pipe
  import rgb_filter_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode,
  input  logic [1:0]      key_sel,
  input  logic [CW-1:0]   key_hi,
  input  logic [CW-1:0]   key_lo,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [3*CW-1:0] s_pixel,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [3*CW-1:0] m_pixel,
  output logic            m_last
);
  logic            en;
  logic [CW-1:0]   r, g, b, y, kc, o1, o2;
  logic            hit, bin;
  logic            v1, l1, hit1, bin1;
  logic [3*CW-1:0] px1, kmask, gray, out;
  logic [CW-1:0]   y1;
  mode_e           mode1;
  logic [1:0]      ks1;

  assign en      = !m_valid || m_ready;
  assign s_ready = en;
  assign {r, g, b} = s_pixel;

  rgb_luma #(.CW(CW)) u_luma (.pixel(s_pixel), .y(y));

  // key_sel 3 falls through to the red-key case
  assign kc  = key_sel == KEY_G ? g : key_sel == KEY_B ? b : r;
  assign o1  = (key_sel == KEY_G || key_sel == KEY_B) ? r : g;
  assign o2  = key_sel == KEY_B ? g : b;
  assign hit = kc > key_hi && o1 < key_lo && o2 < key_lo;
  assign bin = y >= key_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      l1    <= 1'b0;
      px1   <= '0;
      y1    <= '0;
      hit1  <= 1'b0;
      bin1  <= 1'b0;
      mode1 <= MODE_PASS;
      ks1   <= '0;
    end else if (en) begin
      v1    <= s_valid;
      l1    <= s_last;
      px1   <= s_pixel;
      y1    <= y;
      hit1  <= hit;
      bin1  <= bin;
      mode1 <= mode_e'(mode);
      ks1   <= key_sel;
    end
  end

  assign kmask = ks1 == KEY_G ? {{CW{1'b0}}, {CW{1'b1}}, {CW{1'b0}}}
               : ks1 == KEY_B ? {{2*CW{1'b0}}, {CW{1'b1}}}
               : {{CW{1'b1}}, {2*CW{1'b0}}};
  assign gray  = {3{y1}};
  assign out   = mode1 == MODE_PASS ? px1
               : mode1 == MODE_GRAY ? gray
               : mode1 == MODE_KEY  ? (hit1 ? (px1 & kmask) : gray)
               : (bin1 ? {3*CW{1'b1}} : {3*CW{1'b0}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_pixel <= '0;
      m_last  <= 1'b0;
    end else if (en) begin
      m_valid <= v1;
      m_pixel <= out;
      m_last  <= l1;
    end
  end
endmodule

// File: tb/tb_rgb_color_key_pipe.sv
// tb_rgb_color_key_pipe: scoreboard bench with directed and randomized pixel streams
module tb_rgb_color_key_pipe;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [1:0]  mode = 0, key_sel = 0;
  logic [3:0]  key_hi = 0, key_lo = 0;
  logic        s_valid = 0, s_last = 0, m_ready = 0;
  logic [11:0] s_pixel = 0;
  logic        s_ready, m_valid, m_last;
  logic [11:0] m_pixel;

  int          n_cmp = 0, n_bad = 0, cyc = 0, n_out = 0, mv_cyc = -1, last_out_cyc = -1;
  bit          acc, use_dir;
  logic [11:0] dir_exp;
  logic [12:0] expq[$];

  rgb_color_key_pipe #(.CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .key_sel(key_sel), .key_hi(key_hi),
    .key_lo(key_lo), .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_pixel(m_pixel),
    .m_last(m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] model(logic [11:0] p, logic [1:0] md, logic [1:0] ks,
                                        logic [3:0] hi, logic [3:0] lo, logic l);
    int r, g, b, y, k, a1, a2;
    logic [3:0] yy;
    logic [11:0] o;
    r = int'(p[11:8]); g = int'(p[7:4]); b = int'(p[3:0]);
    y = (77 * r + 150 * g + 29 * b + 128) / 256;
    yy = 4'(y);
    k = (ks == 1) ? g : (ks == 2) ? b : r;
    a1 = (ks == 0 || ks == 3) ? g : r;
    a2 = (ks == 2) ? g : b;
    case (md)
      2'd0: o = p;
      2'd1: o = {yy, yy, yy};
      2'd2: o = (k > int'(hi) && a1 < int'(lo) && a2 < int'(lo))
                ? ((ks == 1) ? (p & 12'h0F0) : (ks == 2) ? (p & 12'h00F) : (p & 12'hF00))
                : {yy, yy, yy};
      default: o = (y >= int'(hi)) ? 12'hFFF : 12'h000;
    endcase
    return {l, o};
  endfunction

  task automatic step();
    logic [12:0] e;
    #1;
    acc = s_valid && s_ready;
    if (m_valid && mv_cyc < 0) mv_cyc = cyc;
    if (m_valid && m_ready) begin
      n_cmp++;
      n_out++;
      last_out_cyc = cyc;
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard: unexpected output last=%0b pixel=%h", m_last, m_pixel);
      end else begin
        e = expq.pop_front();
        if ({m_last, m_pixel} !== e)
          begin n_bad++; $display("FAIL scoreboard: got %h want %h", {m_last, m_pixel}, e); end
      end
    end
    if (acc) expq.push_back(use_dir ? {s_last, dir_exp} : model(s_pixel, mode, key_sel, key_hi, key_lo, s_last));
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(logic [11:0] p, logic l, logic [11:0] ex, logic [1:0] md, logic [1:0] ks,
                      logic [3:0] hi, logic [3:0] lo, output int acc_cyc);
    use_dir = 1; dir_exp = ex;
    s_pixel = p; s_last = l; mode = md; key_sel = ks; key_hi = hi; key_lo = lo; s_valid = 1;
    acc_cyc = -1;
    for (int i = 0; i < 20 && acc_cyc < 0; i++) begin
      if (cyc >= 0) begin
        int c0 = cyc;
        step();
        if (acc) acc_cyc = c0;
      end
    end
    n_cmp++;
    if (acc_cyc < 0) begin n_bad++; $display("FAIL send_timeout: pixel %h accepted=0 want 1", p); end
  endtask

  task automatic drain();
    s_valid = 0; m_ready = 1;
    for (int i = 0; i < 50 && expq.size() != 0; i++) step();
    step();
    n_cmp++;
    if (expq.size() != 0) begin n_bad++; $display("FAIL drain_timeout: pending=%0d want 0", expq.size()); end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({m_valid, m_last, m_pixel, s_ready} !== {1'b0, 1'b0, 12'h000, 1'b1})
      begin n_bad++; $display("FAIL reset_state: valid=%b last=%b pixel=%h ready=%b want 0 0 000 1", m_valid, m_last, m_pixel, s_ready); end
    @(negedge clk) rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_gray();
    int a0, a;
    m_ready = 1; n_out = 0; mv_cyc = -1;
    send(12'h888, 0, 12'h888, 1, 0, 0, 0, a0);
    send(12'hFFF, 0, 12'hFFF, 1, 0, 0, 0, a);
    send(12'h000, 1, 12'h000, 1, 0, 0, 0, a);
    drain();
    n_cmp++;
    if (mv_cyc - a0 != 2) begin n_bad++; $display("FAIL gray_latency: got %0d want 2", mv_cyc - a0); end
    n_cmp++;
    if (n_out != 3 || last_out_cyc - mv_cyc != 2)
      begin n_bad++; $display("FAIL gray_throughput: outs=%0d span=%0d want 3 2", n_out, last_out_cyc - mv_cyc); end
  endtask

  task automatic test_key();
    int a;
    m_ready = 1;
    send(12'hB77, 0, 12'hB00, 2, 0, 10, 8, a);
    send(12'hF00, 0, 12'hF00, 2, 0, 10, 8, a);
    send(12'hA00, 0, 12'h333, 2, 0, 10, 8, a);
    send(12'hB87, 0, 12'h999, 2, 0, 10, 8, a);
    send(12'h22C, 0, 12'h00C, 2, 2, 10, 8, a);
    send(12'h5A3, 1, 12'h5A3, 0, 2, 10, 8, a);
    drain();
  endtask

  task automatic test_bin();
    int a;
    m_ready = 1;
    send(12'h888, 0, 12'hFFF, 3, 0, 8, 0, a);
    send(12'h777, 1, 12'h000, 3, 0, 8, 0, a);
    drain();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    use_dir = 1; mode = 0; n_out = 0;
    for (int k = 0; k < 40 && idx < 5; k++) begin
      s_valid = 1;
      s_pixel = 12'(12'h111 * (idx + 1));
      s_last = (idx == 4);
      dir_exp = s_pixel;
      m_ready = (k >= 5);
      step();
      if (acc) idx++;
      if (k == 4) begin
        n_cmp++;
        if ({s_ready, m_valid, m_pixel} !== {1'b0, 1'b1, 12'h111} || idx != 2)
          begin n_bad++; $display("FAIL bp_stall: ready=%b valid=%b pixel=%h accepted=%0d want 0 1 111 2", s_ready, m_valid, m_pixel, idx); end
      end
    end
    drain();
    n_cmp++;
    if (n_out != 5) begin n_bad++; $display("FAIL bp_count: got %0d want 5", n_out); end
  endtask

  task automatic test_mode_switch_reset();
    int a;
    m_ready = 1;
    send(12'h5A3, 0, 12'h888, 1, 0, 0, 0, a);
    send(12'h5A3, 1, 12'h5A3, 0, 0, 0, 0, a);
    drain();
    send(12'hC00, 0, 12'hC00, 0, 0, 0, 0, a);
    send(12'h3C0, 1, 12'h3C0, 0, 0, 0, 0, a);
    s_valid = 0;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({m_valid, m_pixel} !== {1'b0, 12'h000})
      begin n_bad++; $display("FAIL reset_flush: valid=%b pixel=%h want 0 000", m_valid, m_pixel); end
    expq.delete();
    @(negedge clk) rst_n = 1;
    n_out = 0;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (n_out != 0) begin n_bad++; $display("FAIL reset_ghost: outputs=%0d want 0", n_out); end
    send(12'h0F0, 1, 12'h0F0, 0, 0, 0, 0, a);
    drain();
    n_cmp++;
    if (n_out != 1) begin n_bad++; $display("FAIL reset_first: outputs=%0d want 1", n_out); end
  endtask

  task automatic test_random();
    bit stall;
    logic [11:0] hold;
    use_dir = 0;
    for (int k = 0; k < 400; k++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_pixel = 12'($urandom);
      s_last = ($urandom_range(0, 7) == 0);
      mode = 2'($urandom);
      key_sel = 2'($urandom);
      key_hi = 4'($urandom);
      key_lo = 4'($urandom);
      m_ready = ($urandom_range(0, 2) != 0);
      stall = m_valid && !m_ready;
      hold = m_pixel;
      step();
      if (stall) begin
        n_cmp++;
        if ({m_valid, m_pixel} !== {1'b1, hold})
          begin n_bad++; $display("FAIL rand_hold: valid=%b pixel=%h want 1 %h", m_valid, m_pixel, hold); end
      end
    end
    drain();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_gray();
    test_key();
    test_bin();
    test_backpressure();
    test_mode_switch_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rgb_color_key_pipe.md
Name: rgb_color_key_pipe

Overview:
- Streaming, pipelined successor to the combinational RGB greyscale / red-key filter.
- Takes packed RGB pixels of parametrised channel width over a valid/ready stream.
- Applies one of four runtime modes: passthrough, greyscale, colour-key (one selectable channel kept, rest greyscale), threshold binarise.
- Sits between the camera/frame-buffer read path and the VGA output path; stalls cleanly under downstream backpressure.

Parameters:
- CW, 4, bits per colour channel; pixel width is 3*CW, packed {R,G,B}, R in MSBs.
- SUM_W, CW+9, width of the weighted-sum accumulator (derived; not to be overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  0 passthrough, 1 greyscale, 2 colour-key, 3 binarise; sampled with each accepted pixel
- key_sel  in  2  key channel for mode 2: 0 R, 1 G, 2 B, 3 treated as R
- key_hi  in  CW  key channel must be strictly greater than this value (mode 2); binarise threshold (mode 3)
- key_lo  in  CW  the other two channels must be strictly less than this value (mode 2)
- s_valid  in  1  input pixel valid
- s_ready  out  1  block can accept an input pixel
- s_pixel  in  3*CW  input pixel {R,G,B}
- s_last  in  1  end-of-line marker; travels with the pixel
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts the output pixel
- m_pixel  out  3*CW  output pixel
- m_last  out  1  end-of-line marker aligned with m_pixel

Behaviour:
- Reset: all stage valid bits 0, m_valid=0, m_pixel=0, m_last=0. s_ready is combinational and therefore reads 1 during reset.
- Two register stages with one global advance enable: en = !m_valid || m_ready; s_ready = en.
- Transfer occurs when valid && ready on each side. With no stall, latency is exactly 2 cycles from input accept to m_valid, at a throughput of 1 pixel/clk.
- Stall: when en=0, both stages hold their data, valid and last bits. No pixel is dropped or duplicated, and m_pixel stays stable while m_valid=1 && m_ready=0.
- Bubbles: s_valid=0 with en=1 shifts a 0 valid bit through the pipeline.
- Stage 1, registered on accept:
  - Y = (77*R + 150*G + 29*B + 128) >> 8, truncated to CW bits.
  - Weights sum to 256, so Y never exceeds 2^CW-1 and no saturation is needed.
  - Key hit = keych > key_hi && other1 < key_lo && other2 < key_lo, all unsigned compares.
  - Stage 1 also registers the original pixel, mode, key_sel and last.
- Stage 2 output select:
  - mode 0: original pixel.
  - mode 1: {Y,Y,Y}.
  - mode 2: on a key hit, keep the key channel in place and zero the other two; otherwise {Y,Y,Y}.
  - mode 3: {max,max,max} when Y >= key_hi, else all zeros.
- Mode, key_sel, key_hi and key_lo are sampled at input accept only. A change mid-stream affects only pixels accepted after the change; in-flight pixels keep their own sampled controls.
- Reset asserted mid-operation: in-flight pixels are discarded immediately. The first post-reset output is the first pixel accepted after rst_n deasserts.

Decomposition:
- Shared package rgb_filter_pkg:
  - mode encodings MODE_PASS/MODE_GRAY/MODE_KEY/MODE_BIN
  - key_sel encodings KEY_R/KEY_G/KEY_B
  - luma weight constants W_R=77, W_G=150, W_B=29, plus rounding constant 128
- One sub-module: rgb_luma, purely combinational, parametrised by CW, computing Y from {R,G,B}.
- Key compare and output mux stay in the top level.

Test Plan (CW=4):
- Mode 1, continuous stream 0x888, 0xFFF, 0x000 with m_ready=1 -> outputs 0x888, 0xFFF, 0x000, first m_valid exactly 2 clk after the first accept, one output per clk.
- Mode 2, key_sel=0, key_hi=10, key_lo=8: input 0xB77 -> 0xB00; 0xF00 -> 0xF00; 0xA00 (R not >10) -> 0x333; 0xB87 (G not <8) -> greyscale {Y,Y,Y}.
- Mode 2, key_sel=2, same thresholds: 0x22C -> 0x00C; mode 0: 0x5A3 -> 0x5A3 unchanged.
- Mode 3, key_hi=8: 0x888 (Y=8) -> 0xFFF; 0x777 (Y=7) -> 0x000.
- Backpressure: hold m_ready=0 for 5 clk while s_valid=1 with pixels 0x111..0x555 -> s_ready drops once both stages are full, m_pixel is stable, then all pixels emerge in order with matching m_last and none lost.
- Switch mode 1->0 between consecutive accepted pixels, then pulse rst_n low for 1 clk with 2 pixels in flight -> the mode switch applies per pixel; after reset m_valid=0 and the in-flight pixels never appear.
